addaccu_gen: RTL and testbench

ADDACCU_GEN -- requirements
Module: addaccu_gen

---
 rtl/addaccu_pkg.sv | 21 ++
 rtl/addaccu_addsub.sv | 23 ++
 rtl/addaccu_gen.sv | 117 +++++++++++
 tb/tb_addaccu_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addaccu_pkg.sv
// Shared encodings for the add/accumulate block: operation modes and FSM states.
package addaccu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_ACC = 2'b01,
    MODE_SUB = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width able to hold 0..acc_len, never narrower than one bit.
  function automatic int count_width(input int acc_len);
    return (acc_len < 1) ? 1 : $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/addaccu_addsub.sv
// Combinational WIDTH-bit adder/subtractor producing a WIDTH+1-bit result.
// The top bit is the carry-out for an add and the borrow for a subtract.
module addaccu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH:0]   res,
  output logic             cout
);

  // Zero-extend both operands so bit WIDTH is carry (add) or borrow (sub, y > x).
  always_comb begin
    if (sub) begin
      res = {1'b0, x} - {1'b0, y};
    end else begin
      res = {1'b0, x} + {1'b0, y};
    end
    cout = res[WIDTH];
  end

endmodule

// File: rtl/addaccu_gen.sv
// Registered adder / accumulator with optional saturation, sticky overflow
// and periodic dump of the accumulated result every ACC_LEN ACC/SUB ops.
module addaccu_gen
  import addaccu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int ACC_LEN = 0,
  parameter int SAT_EN  = 0
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_vld,
  output logic             ovf,
  output logic             dump
);

  localparam int CW = count_width(ACC_LEN);
  localparam logic [CW-1:0] COUNT_LAST = CW'(ACC_LEN);

  state_e          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;
  mode_e           op;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] x;
  logic            sub;
  logic [WIDTH:0]  res;
  logic            cout;
  logic [WIDTH-1:0] result;
  logic            hit;

  addaccu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (x),
    .y    (b),
    .sub  (sub),
    .res  (res),
    .cout (cout)
  );

  // Operand selection, saturation of ACC/SUB results and dump detection.
  always_comb begin
    op        = mode_e'(mode);
    base      = (state == RUN) ? sum : '0;
    x         = (op == MODE_ADD) ? a : base;
    sub       = (op == MODE_SUB);
    count_inc = count + CW'(1);
    hit       = (ACC_LEN > 0) && (count_inc == COUNT_LAST);
    result    = res[WIDTH-1:0];
    if ((SAT_EN != 0) && cout && (op == MODE_ACC)) begin
      result = '1;
    end
    if ((SAT_EN != 0) && cout && (op == MODE_SUB)) begin
      result = '0;
    end
  end

  // Result, flag, counter and FSM registers; idle cycles hold everything but the strobes.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      carry   <= 1'b0;
      out_vld <= 1'b0;
      ovf     <= 1'b0;
      dump    <= 1'b0;
      count   <= '0;
      state   <= IDLE;
    end else begin
      out_vld <= in_vld;
      dump    <= 1'b0;
      if (in_vld) begin
        case (op)
          MODE_ADD: begin
            sum   <= res[WIDTH-1:0];
            carry <= cout;
            count <= '0;
            state <= RUN;
          end
          MODE_ACC, MODE_SUB: begin
            sum   <= result;
            carry <= cout;
            if (cout) begin
              ovf <= 1'b1;
            end
            if (ACC_LEN == 0) begin
              count <= '0;
              state <= RUN;
            end else if (hit) begin
              dump  <= 1'b1;
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count_inc;
              state <= RUN;
            end
          end
          MODE_CLR: begin
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
            state <= IDLE;
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_addaccu_gen.sv
// Self-checking bench: four configurations of addaccu_gen driven in parallel,
// a behavioural model per configuration feeding a scoreboard queue.
module tb_addaccu_gen;

  localparam int NCFG = 4;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;

  logic [NCFG-1:0][3:0] sum_o;
  logic [NCFG-1:0]      carry_o;
  logic [NCFG-1:0]      vld_o;
  logic [NCFG-1:0]      ovf_o;
  logic [NCFG-1:0]      dump_o;

  int n_checks = 0;
  int n_fails  = 0;

  int m_sum   [NCFG];
  int m_carry [NCFG];
  int m_vld   [NCFG];
  int m_ovf   [NCFG];
  int m_dump  [NCFG];
  int m_cnt   [NCFG];
  int m_run   [NCFG];

  typedef struct {
    int cfg;
    int sum;
    int carry;
    int vld;
    int ovf;
    int dump;
  } exp_t;

  exp_t sb[$];

  int exp034_wrap [4] = '{5, 10, 15, 4};
  int exp035_sat  [4] = '{5, 10, 15, 15};
  int exp034_cy   [4] = '{0, 0, 0, 1};
  int exp037_sum  [4] = '{2, 4, 6, 2};
  int exp037_dump [4] = '{0, 0, 1, 0};
  int exp038_vld  [3] = '{1, 0, 1};
  int exp038_sum  [3] = '{1, 1, 2};

  // cfg0: wrap, no dump; cfg1: saturate, no dump; cfg2: saturate, ACC_LEN=3; cfg3: wrap, ACC_LEN=1
  addaccu_gen #(.WIDTH(4), .ACC_LEN(0), .SAT_EN(0)) u_c0 (
    .ck(ck), .rst_n(rst_n), .in_vld(in_vld), .mode(mode), .a(a), .b(b),
    .sum(sum_o[0]), .carry(carry_o[0]), .out_vld(vld_o[0]), .ovf(ovf_o[0]), .dump(dump_o[0]));
  addaccu_gen #(.WIDTH(4), .ACC_LEN(0), .SAT_EN(1)) u_c1 (
    .ck(ck), .rst_n(rst_n), .in_vld(in_vld), .mode(mode), .a(a), .b(b),
    .sum(sum_o[1]), .carry(carry_o[1]), .out_vld(vld_o[1]), .ovf(ovf_o[1]), .dump(dump_o[1]));
  addaccu_gen #(.WIDTH(4), .ACC_LEN(3), .SAT_EN(1)) u_c2 (
    .ck(ck), .rst_n(rst_n), .in_vld(in_vld), .mode(mode), .a(a), .b(b),
    .sum(sum_o[2]), .carry(carry_o[2]), .out_vld(vld_o[2]), .ovf(ovf_o[2]), .dump(dump_o[2]));
  addaccu_gen #(.WIDTH(4), .ACC_LEN(1), .SAT_EN(0)) u_c3 (
    .ck(ck), .rst_n(rst_n), .in_vld(in_vld), .mode(mode), .a(a), .b(b),
    .sum(sum_o[3]), .carry(carry_o[3]), .out_vld(vld_o[3]), .ovf(ovf_o[3]), .dump(dump_o[3]));

  // Free-running 10 ns clock.
  always #5 ck = ~ck;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int cfgLen(input int i);
    return (i == 2) ? 3 : (i == 3) ? 1 : 0;
  endfunction

  function automatic int cfgSat(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NCFG; i++) begin
      m_sum[i] = 0; m_carry[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
      m_dump[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic modelStep(input int i, input bit vld, input int md, input int av, input int bv);
    int base;
    int full;
    int ev;
    int nsum;
    m_dump[i] = 0;
    m_vld[i]  = vld ? 1 : 0;
    if (vld) begin
      if (md == 0) begin
        full = av + bv;
        m_sum[i] = full % 16;
        m_carry[i] = full / 16;
        m_cnt[i] = 0;
        m_run[i] = 1;
      end else if (md == 3) begin
        m_sum[i] = 0; m_carry[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
      end else begin
        base = m_run[i] ? m_sum[i] : 0;
        if (md == 1) begin
          full = base + bv;
          ev = (full > 15) ? 1 : 0;
          nsum = (ev && cfgSat(i)) ? 15 : full % 16;
        end else begin
          ev = (bv > base) ? 1 : 0;
          nsum = (ev && cfgSat(i)) ? 0 : (base - bv + 16) % 16;
        end
        m_sum[i] = nsum;
        m_carry[i] = ev;
        if (ev) m_ovf[i] = 1;
        if (cfgLen(i) > 0) begin
          m_cnt[i]++;
          if (m_cnt[i] == cfgLen(i)) begin
            m_dump[i] = 1;
            m_cnt[i] = 0;
            m_run[i] = 0;
          end else begin
            m_run[i] = 1;
          end
        end else begin
          m_run[i] = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit vld, input int md, input int av, input int bv);
    exp_t e;
    @(negedge ck);
    in_vld = vld;
    mode   = 2'(md);
    a      = 4'(av);
    b      = 4'(bv);
    for (int i = 0; i < NCFG; i++) begin
      modelStep(i, vld, md, av, bv);
      sb.push_back('{cfg: i, sum: m_sum[i], carry: m_carry[i], vld: m_vld[i],
                     ovf: m_ovf[i], dump: m_dump[i]});
    end
    @(posedge ck);
    #1;
    for (int i = 0; i < NCFG; i++) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("c%0d_sum", e.cfg),   32'(sum_o[e.cfg]),   32'(e.sum));
        checkOutput($sformatf("c%0d_carry", e.cfg), 32'(carry_o[e.cfg]), 32'(e.carry));
        checkOutput($sformatf("c%0d_vld", e.cfg),   32'(vld_o[e.cfg]),   32'(e.vld));
        checkOutput($sformatf("c%0d_ovf", e.cfg),   32'(ovf_o[e.cfg]),   32'(e.ovf));
        checkOutput($sformatf("c%0d_dump", e.cfg),  32'(dump_o[e.cfg]),  32'(e.dump));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      checkOutput($sformatf("%s_c%0d_sum", tag, i),   32'(sum_o[i]),   32'd0);
      checkOutput($sformatf("%s_c%0d_carry", tag, i), 32'(carry_o[i]), 32'd0);
      checkOutput($sformatf("%s_c%0d_vld", tag, i),   32'(vld_o[i]),   32'd0);
      checkOutput($sformatf("%s_c%0d_ovf", tag, i),   32'(ovf_o[i]),   32'd0);
      checkOutput($sformatf("%s_c%0d_dump", tag, i),  32'(dump_o[i]),  32'd0);
    end
  endtask

  // Asynchronous reset pulse entirely between two rising edges.
  task automatic resetPulse(input string tag);
    @(negedge ck);
    #1;
    in_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkAllZero(tag);
    resetModel();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int md;
    bit vld;
    resetModel();
    $display("[TB] start");
    #2;
    checkAllZero("por");
    @(negedge ck);
    rst_n = 1'b1;

    // Four ACC b=5: wrap vs saturate
    applyStimulus(1'b1, 3, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1, 0, 5);
      checkOutput("r034_sum", 32'(sum_o[0]), 32'(exp034_wrap[k]));
      checkOutput("r034_carry", 32'(carry_o[0]), 32'(exp034_cy[k]));
      checkOutput("r035_sum", 32'(sum_o[1]), 32'(exp035_sat[k]));
      checkOutput("r035_carry", 32'(carry_o[1]), 32'(exp034_cy[k]));
    end
    checkOutput("r034_ovf", 32'(ovf_o[0]), 32'd1);
    checkOutput("r035_ovf", 32'(ovf_o[1]), 32'd1);

    // Dump every third ACC with b=2
    applyStimulus(1'b1, 3, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1, 0, 2);
      checkOutput("r037_sum", 32'(sum_o[2]), 32'(exp037_sum[k]));
      checkOutput("r037_dump", 32'(dump_o[2]), 32'(exp037_dump[k]));
      checkOutput("r027_sum", 32'(sum_o[3]), 32'd2);
      checkOutput("r027_dump", 32'(dump_o[3]), 32'd1);
    end

    // ADD, borrowing SUB, CLR
    applyStimulus(1'b1, 3, 0, 0);
    applyStimulus(1'b1, 0, 3, 4);
    checkOutput("r036_add_sum", 32'(sum_o[0]), 32'd7);
    applyStimulus(1'b1, 2, 0, 9);
    checkOutput("r036_sub_sum", 32'(sum_o[0]), 32'd14);
    checkOutput("r036_sub_carry", 32'(carry_o[0]), 32'd1);
    checkOutput("r036_sub_ovf", 32'(ovf_o[0]), 32'd1);
    applyStimulus(1'b1, 3, 0, 0);
    checkOutput("r036_clr_sum", 32'(sum_o[0]), 32'd0);
    checkOutput("r036_clr_carry", 32'(carry_o[0]), 32'd0);
    checkOutput("r036_clr_ovf", 32'(ovf_o[0]), 32'd0);

    // in_vld gap during accumulation
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k != 1, 1, 0, 1);
      checkOutput("r038_vld", 32'(vld_o[0]), 32'(exp038_vld[k]));
      checkOutput("r038_sum", 32'(sum_o[0]), 32'(exp038_sum[k]));
    end

    // Reset mid-accumulation
    applyStimulus(1'b1, 3, 0, 0);
    applyStimulus(1'b1, 1, 0, 5);
    applyStimulus(1'b1, 1, 0, 5);
    checkOutput("r039_pre_sum", 32'(sum_o[0]), 32'd10);
    resetPulse("r039_rst");
    applyStimulus(1'b1, 1, 0, 3);
    checkOutput("r039_post_sum", 32'(sum_o[0]), 32'd3);

    // Random traffic with an occasional reset pulse
    for (int n = 0; n < 400; n++) begin
      if (n == 200) resetPulse("rnd_rst");
      r   = $urandom_range(0, 9);
      md  = (r == 0) ? 3 : (r < 4) ? 1 : (r < 7) ? 2 : 0;
      vld = ($urandom_range(0, 3) != 0);
      applyStimulus(vld, md, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    checkOutput("sb_left", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
